dcs_out_quant: RTL and testbench
================================

Name: dcs_out_quant

Overview:
- Downstream stage of the DCSformer attention core. Consumes the 8-word, 32-bit result burst (core o_valid/o_data) and requantizes each frame to 8-bit with one shared per-frame right-shift exponent.
- Emits the bytes over a valid/ready stream with a frame-last marker.
- The core has no backpressure, so the block holds two frames in ping-pong buffers. If a third frame arrives while both are full, the whole frame is dropped and flagged.

Parameters:
- IN_W, 32, input word width (matches core o_data).
- N_WORDS, 8, words per frame (one per attention row).
- OUT_W, 8, output byte width.
- SHIFT_W, 5, width of the exponent output (range 0..IN_W-OUT_W).
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active-high (1 = reset); port name kept per codebase.
- in_valid  in  1  input word strobe (core o_valid); no ready, always accepted or dropped.
- in_data  in  IN_W  unsigned input word (core o_data).
- out_valid  out  1  output byte valid.
- out_ready  in  1  downstream accepts the byte when out_valid&&out_ready.
- out_data  out  OUT_W  requantized unsigned byte.
- out_shift  out  SHIFT_W  frame exponent, constant for all bytes of a frame.
- out_last  out  1  high with the N_WORDS-th byte of a frame.
- drop_pulse  out  1  one-cycle pulse when a frame finishes being dropped.
- drop_cnt  out  CNT_W  saturating count of dropped frames.

Behaviour:
- Reset, asynchronous: all outputs 0. Both buffers empty. Write/read pointers, word counter and running max are 0. Drop state is cleared. Any in-flight frame is discarded, no partial output.
- Capture:
  - Word index wcnt increments only on in_valid cycles; gaps inside a frame are allowed.
  - Word 0 of a frame decides the target. If a buffer is free, the frame is written to the write buffer. If both are full, the frame enters DROP mode and all N_WORDS words are discarded.
  - Running max is unsigned; it resets on word 0.
- Frame close, at the edge accepting word N_WORDS-1:
  - Compute shift from max including that word: s = max(0, bitlen(max) - OUT_W); max = 0 gives s = 0.
  - Register s with the buffer, mark the buffer full and toggle the write pointer.
  - In DROP mode the close instead pulses drop_pulse for one cycle and increments drop_cnt, saturating at 2^CNT_W-1.
- Quantization, per word v at read time:
  - If s = 0, q = v.
  - Otherwise q = (v + 2^(s-1)) >> s, with the add done in IN_W+1 bits.
  - Saturate q to 2^OUT_W-1.
- Output FSM: EMPTY -> STREAM (head buffer full) -> EMPTY or STREAM.
  - out_valid is high whenever the read buffer is full. out_valid rises the cycle after the frame-close edge (latency 1 from last input word).
  - A byte index advances on each handshake. out_data, out_shift and out_last hold stable while out_valid && !out_ready.
  - The handshake on the last byte frees the buffer and toggles the read pointer. The next full buffer streams on the following cycle with no bubble.
- Simultaneous events:
  - A frame close and the freeing of the other buffer in the same cycle both take effect.
  - Word 0 arriving in the cycle a buffer is freed sees the buffer as free (free evaluated after that cycle's read handshake).
- Frames leave in arrival order. A dropped frame never produces output.

Test Plan:
- Frame 10,20,...,80, out_ready=1 -> out_shift=0; bytes 10..80 on consecutive cycles; out_valid rises 1 cycle after word 8; out_last only on 80.
- Frame {1023,6,1000,0,0,0,0,0} -> out_shift=2; bytes 255 (1025>>2=256 saturated), 2, 250, 0...
- Frame with word 0xFFFFFFFF, others 3 -> shift 24; bytes 255 and 0; no 32-bit wrap in the rounding add.
- out_ready=0, three back-to-back frames -> frame 3 dropped, drop_pulse once, drop_cnt=1. Then out_ready=1 yields frame 1 then frame 2 with no bubble, then out_valid=0.
- Frame words split by in_valid gaps of 0-3 cycles -> identical output to the gapless case.
- Assert rst_n mid-stream (byte 3 of 8) and mid-capture -> out_valid=0 immediately, drop_cnt=0; the next full frame streams correctly from byte 0.

Source files
------------

// File: rtl/dcs_out_quant_if.sv
// dcs_out_quant_if: groups the capture and output stream signals of dcs_out_quant.
//   master : producer side (drives in_valid/in_data and out_ready, observes outputs)
//   slave  : the quantizer itself
// Signals:
//   in_valid/in_data          word burst from the attention core (no backpressure)
//   out_valid/out_ready       byte stream handshake
//   out_data/out_shift/out_last  requantized byte, frame exponent, frame-last marker
//   drop_pulse/drop_cnt       dropped-frame pulse and saturating counter
interface dcs_out_quant_if #(
  parameter int IN_W    = 32,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 5,
  parameter int CNT_W   = 8
);
  logic               in_valid;
  logic [IN_W-1:0]    in_data;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_data;
  logic [SHIFT_W-1:0] out_shift;
  logic               out_last;
  logic               drop_pulse;
  logic [CNT_W-1:0]   drop_cnt;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_shift, out_last, drop_pulse, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_shift, out_last, drop_pulse, drop_cnt
  );
endinterface

// File: rtl/dcs_out_quant.sv
// dcs_out_quant: requantizes 8-word, 32-bit attention-core result frames to
// 8-bit bytes with one shared right-shift exponent per frame. Two ping-pong
// frame buffers absorb the core's lack of backpressure; a frame whose first
// word finds both buffers full is discarded whole and counted.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous reset, active-high (1 = reset) despite the name
//   bus    dcs_out_quant_if.slave: in_valid/in_data capture, out_* stream,
//          drop_pulse/drop_cnt drop reporting
module dcs_out_quant #(
  parameter int IN_W    = 32,
  parameter int N_WORDS = 8,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 5,
  parameter int CNT_W   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  dcs_out_quant_if.slave  bus
);

  localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  typedef enum logic {S_EMPTY, S_STREAM} state_t;

  // Exponent so that the frame maximum fits in OUT_W bits after shifting.
  function automatic logic [SHIFT_W-1:0] f_shift(input logic [IN_W-1:0] m);
    int len;
    len = 0;
    for (int i = 0; i < IN_W; i++) begin
      if (m[i]) len = i + 1;
    end
    if (len > OUT_W) return SHIFT_W'(len - OUT_W);
    return '0;
  endfunction

  // Round-half-up right shift with saturation; the add carries into bit IN_W
  // so an all-ones word cannot wrap to a small value.
  function automatic logic [OUT_W-1:0] f_quant(input logic [IN_W-1:0] v,
                                               input logic [SHIFT_W-1:0] s);
    logic [IN_W:0] sum;
    if (s == '0) begin
      sum = {1'b0, v};
    end else begin
      sum = ({1'b0, v} + ((IN_W+1)'(1) << (s - SHIFT_W'(1)))) >> s;
    end
    if (sum > (IN_W+1)'((1 << OUT_W) - 1)) return '1;
    return sum[OUT_W-1:0];
  endfunction

  logic [IN_W-1:0]    r_buf   [2][N_WORDS];
  logic [SHIFT_W-1:0] r_shift [2];
  logic [1:0]         r_full;
  logic               r_wptr;
  logic               r_rptr;
  logic [IDX_W-1:0]   r_wcnt;
  logic [IDX_W-1:0]   r_bidx;
  logic [IN_W-1:0]    r_max;
  logic               r_drop;
  logic               r_drop_pulse;
  logic [CNT_W-1:0]   r_drop_cnt;
  state_t             r_state;

  logic               w_out_valid;
  logic               w_hs;
  logic               w_last_hs;
  logic [1:0]         w_full_after;
  logic [1:0]         w_full_nxt;
  logic               w_wptr_nxt;
  logic               w_rptr_nxt;
  logic               w_drop_cur;
  logic               w_close;
  logic [IN_W-1:0]    w_max_new;
  state_t             w_state_nxt;

  assign w_out_valid = (r_state == S_STREAM);
  assign w_hs        = w_out_valid && bus.out_ready;
  assign w_last_hs   = w_hs && (r_bidx == LAST_IDX);
  assign w_close     = bus.in_valid && (r_wcnt == LAST_IDX);

  always_comb begin
    w_full_after = r_full;
    w_full_nxt   = r_full;
    w_wptr_nxt   = r_wptr;
    w_rptr_nxt   = r_rptr;
    w_drop_cur   = r_drop;
    w_max_new    = r_max;
    w_state_nxt  = r_state;

    // A buffer freed by this cycle's final handshake already counts as free.
    if (w_last_hs) begin
      w_full_after[r_rptr] = 1'b0;
      w_rptr_nxt           = ~r_rptr;
    end

    // Writes proceed in order, so the write-pointer buffer being full means
    // both buffers are full.
    if (r_wcnt == '0) begin
      w_drop_cur = w_full_after[r_wptr];
    end

    if ((r_wcnt == '0) || (bus.in_data > r_max)) begin
      w_max_new = bus.in_data;
    end

    w_full_nxt = w_full_after;
    if (w_close && !w_drop_cur) begin
      w_full_nxt[r_wptr] = 1'b1;
      w_wptr_nxt         = ~r_wptr;
    end

    w_state_nxt = w_full_nxt[w_rptr_nxt] ? S_STREAM : S_EMPTY;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_full       <= '0;
      r_wptr       <= 1'b0;
      r_rptr       <= 1'b0;
      r_wcnt       <= '0;
      r_bidx       <= '0;
      r_max        <= '0;
      r_drop       <= 1'b0;
      r_drop_pulse <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_full       <= w_full_nxt;
      r_wptr       <= w_wptr_nxt;
      r_rptr       <= w_rptr_nxt;
      r_drop_pulse <= 1'b0;

      if (w_last_hs) begin
        r_bidx <= '0;
      end else if (w_hs) begin
        r_bidx <= r_bidx + IDX_W'(1);
      end

      if (bus.in_valid) begin
        r_wcnt <= w_close ? '0 : r_wcnt + IDX_W'(1);
        r_max  <= w_max_new;
        if (r_wcnt == '0) r_drop <= w_drop_cur;
        if (w_close && w_drop_cur) begin
          r_drop_pulse <= 1'b1;
          if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Frame storage carries no reset; every output path is gated by valid.
  always_ff @(posedge clk) begin
    if (bus.in_valid && !w_drop_cur) begin
      r_buf[r_wptr][r_wcnt] <= bus.in_data;
    end
    if (w_close && !w_drop_cur) begin
      r_shift[r_wptr] <= f_shift(w_max_new);
    end
  end

  assign bus.out_valid  = w_out_valid;
  assign bus.out_data   = w_out_valid ? f_quant(r_buf[r_rptr][r_bidx], r_shift[r_rptr]) : '0;
  assign bus.out_shift  = w_out_valid ? r_shift[r_rptr] : '0;
  assign bus.out_last   = w_out_valid && (r_bidx == LAST_IDX);
  assign bus.drop_pulse = r_drop_pulse;
  assign bus.drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_dcs_out_quant.sv
module tb_dcs_out_quant;

  typedef logic [7:0][31:0] frame_t;
  typedef struct {
    frame_t          w;
    int              gap;
    int              shift;
    logic [7:0][7:0] b;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   drop_seen = 0;
  bit   rnd_ready = 1'b0;
  bit   ready_cmd = 1'b0;
  int   close_cyc;

  int   q_data[$];
  int   q_shift[$];
  int   q_last[$];
  int   q_cyc[$];
  int   e_data[$];
  int   e_shift[$];
  int   e_last[$];

  vec_t tbl [6];

  dcs_out_quant_if bus ();

  dcs_out_quant dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Output collector and drop-pulse counter, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        q_data.push_back(int'(bus.out_data));
        q_shift.push_back(int'(bus.out_shift));
        q_last.push_back(int'(bus.out_last));
        q_cyc.push_back(cyc);
      end
      if (bus.drop_pulse) drop_seen++;
    end
  end

  // Single driver of out_ready.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rnd_ready ? ($urandom_range(3, 0) != 0) : ready_cmd;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: smallest shift that brings the frame maximum below 256,
  // then round-half-up and clamp, all in wide integer arithmetic.
  function automatic int ref_shift(input frame_t f);
    longint m;
    int s;
    m = 0;
    for (int i = 0; i < 8; i++) if (longint'(f[i]) > m) m = longint'(f[i]);
    s = 0;
    while ((m >> s) > 255) s++;
    return s;
  endfunction

  function automatic int ref_q(input longint v, input int s);
    longint q;
    if (s == 0) q = v;
    else q = (v + (longint'(1) << (s - 1))) >> s;
    if (q > 255) q = 255;
    return int'(q);
  endfunction

  task automatic model_frame(input frame_t f);
    int s;
    s = ref_shift(f);
    for (int i = 0; i < 8; i++) begin
      e_data.push_back(ref_q(longint'(f[i]), s));
      e_shift.push_back(s);
      e_last.push_back(i == 7 ? 1 : 0);
    end
  endtask

  task automatic clear_q();
    q_data.delete(); q_shift.delete(); q_last.delete(); q_cyc.delete();
    e_data.delete(); e_shift.delete(); e_last.delete();
  endtask

  task automatic send_frame(input frame_t f, input int n, input int gmax, input bit lat);
    int g;
    for (int i = 0; i < n; i++) begin
      g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
      repeat (g) begin
        @(posedge clk);
        #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = f[i];
      if (lat && i == n - 1) chk("valid_before_close", bus.out_valid, 0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_bytes(input int n);
    int b;
    b = 0;
    while (q_data.size() < n && b < 400) begin
      @(negedge clk);
      #1;
      b++;
    end
    chk("bytes_arrived", (q_data.size() >= n), 1);
  endtask

  task automatic cmp_model(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_data"},  q_data[i],  e_data[i]);
      chk({tag, "_shift"}, q_shift[i], e_shift[i]);
      chk({tag, "_last"},  q_last[i],  e_last[i]);
    end
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drop_seen = 0;
    clear_q();
  endtask

  function automatic frame_t rnd_frame();
    frame_t f;
    int k;
    k = int'($urandom_range(31, 0));
    for (int i = 0; i < 8; i++) f[i] = $urandom >> k;
    return f;
  endfunction

  initial begin
    frame_t f1, f2, f3, fz;

    // Directed table; expected bytes worked out by hand.
    for (int t = 0; t < 6; t++) begin
      tbl[t].w = '0; tbl[t].b = '0; tbl[t].gap = 0; tbl[t].shift = 0;
    end
    for (int i = 0; i < 8; i++) begin
      tbl[0].w[i] = 32'(10 * (i + 1));
      tbl[0].b[i] = 8'(10 * (i + 1));
    end
    tbl[1].w[0] = 32'd1023; tbl[1].w[1] = 32'd6; tbl[1].w[2] = 32'd1000;
    tbl[1].shift = 2;
    tbl[1].b[0] = 8'd255; tbl[1].b[1] = 8'd2; tbl[1].b[2] = 8'd250;
    tbl[2].w[0] = 32'hFFFF_FFFF;
    for (int i = 1; i < 8; i++) tbl[2].w[i] = 32'd3;
    tbl[2].shift = 24;
    tbl[2].b[0] = 8'd255;
    tbl[3].w[0] = 32'd256; tbl[3].w[1] = 32'd1; tbl[3].w[2] = 32'd3; tbl[3].w[3] = 32'd255;
    tbl[3].shift = 1;
    tbl[3].b[0] = 8'd128; tbl[3].b[1] = 8'd1; tbl[3].b[2] = 8'd2; tbl[3].b[3] = 8'd128;
    tbl[4] = tbl[0];
    tbl[4].gap = 3;
    for (int i = 0; i < 8; i++) begin
      tbl[5].w[i] = 32'(255 - i);
      tbl[5].b[i] = 8'(255 - i);
    end

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid",  bus.out_valid, 0);
    chk("rst_out_data",   bus.out_data, 0);
    chk("rst_out_shift",  bus.out_shift, 0);
    chk("rst_out_last",   bus.out_last, 0);
    chk("rst_drop_pulse", bus.drop_pulse, 0);
    chk("rst_drop_cnt",   bus.drop_cnt, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    ready_cmd = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Table-driven frames with out_ready held high.
    for (int t = 0; t < 6; t++) begin
      clear_q();
      send_frame(tbl[t].w, 8, tbl[t].gap, 1'b1);
      close_cyc = cyc;
      chk("valid_after_close", bus.out_valid, 1);
      wait_bytes(8);
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("tbl%0d_data%0d", t, i), q_data[i], tbl[t].b[i]);
        chk($sformatf("tbl%0d_shift%0d", t, i), q_shift[i], tbl[t].shift);
        chk($sformatf("tbl%0d_last%0d", t, i), q_last[i], (i == 7) ? 1 : 0);
        chk($sformatf("tbl%0d_cycle%0d", t, i), q_cyc[i], close_cyc + i);
      end
      repeat (2) @(negedge clk);
      #1;
      chk("valid_after_frame", bus.out_valid, 0);
    end

    // Three back-to-back frames while stalled: the third is dropped.
    do_reset();
    ready_cmd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    f1 = rnd_frame(); f2 = rnd_frame(); f3 = rnd_frame();
    model_frame(f1);
    model_frame(f2);
    send_frame(f1, 8, 0, 1'b0);
    send_frame(f2, 8, 0, 1'b0);
    send_frame(f3, 8, 0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("drop_pulses", drop_seen, 1);
    chk("drop_cnt_one", bus.drop_cnt, 1);
    chk("stall_valid", bus.out_valid, 1);
    chk("stall_data_a", bus.out_data, e_data[0]);
    chk("stall_shift", bus.out_shift, e_shift[0]);
    repeat (2) @(negedge clk);
    #1;
    chk("stall_data_b", bus.out_data, e_data[0]);
    chk("stall_last", bus.out_last, 0);
    ready_cmd = 1'b1;
    wait_bytes(16);
    for (int i = 0; i < 16; i++) chk($sformatf("nobubble%0d", i), q_cyc[i], q_cyc[0] + i);
    cmp_model("drain", 16);
    repeat (3) @(negedge clk);
    #1;
    chk("drain_valid_low", bus.out_valid, 0);
    chk("drain_extra", q_data.size(), 16);

    // Drop counter saturation: fill both buffers, then drop 256 more frames.
    ready_cmd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    fz = '0;
    send_frame(f1, 8, 0, 1'b0);
    send_frame(f2, 8, 0, 1'b0);
    for (int k = 0; k < 256; k++) send_frame(fz, 8, 0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("drop_cnt_sat", bus.drop_cnt, 255);
    chk("drop_pulses_sat", drop_seen, 257);

    // Reset while streaming byte 3.
    clear_q();
    ready_cmd = 1'b1;
    wait_bytes(3);
    rst_n = 1'b1;
    #1;
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_drop_cnt", bus.drop_cnt, 0);
    chk("midrst_last", bus.out_last, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    clear_q();
    drop_seen = 0;

    // Reset in the middle of capture, then a clean frame.
    send_frame(tbl[1].w, 4, 0, 1'b0);
    do_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("capture_rst_valid", bus.out_valid, 0);
    f1 = rnd_frame();
    model_frame(f1);
    send_frame(f1, 8, 1, 1'b0);
    wait_bytes(8);
    repeat (10) @(negedge clk);
    #1;
    chk("after_rst_count", q_data.size(), 8);
    cmp_model("after_rst", 8);

    // Randomized frames, gaps and backpressure versus the reference model.
    do_reset();
    rnd_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      int b;
      b = 0;
      while (q_data.size() < 8 * (k - 1) && b < 400) begin
        @(posedge clk);
        #1;
        b++;
      end
      f1 = rnd_frame();
      model_frame(f1);
      send_frame(f1, 8, 3, 1'b0);
    end
    wait_bytes(96);
    rnd_ready = 1'b0;
    ready_cmd = 1'b1;
    cmp_model("rand", 96);
    chk("rand_no_drop", drop_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
